// File: rtl/div_sched_pkg.sv
// ---------------------------------------------------------------------------
// div_sched_pkg
// Shared definitions for the divide sequencing controller:
//   - INST_DIV/DIVU/REM/REMU : 3-bit divide opcodes from the EXU decoder
//   - DS_IDLE/RUN/PEND/ABORT : one-hot controller state encodings
// ---------------------------------------------------------------------------
package div_sched_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [3:0] DS_IDLE  = 4'b0001;
    localparam logic [3:0] DS_RUN   = 4'b0010;
    localparam logic [3:0] DS_PEND  = 4'b0100;
    localparam logic [3:0] DS_ABORT = 4'b1000;

endpackage

// File: rtl/div_sched.sv
// ---------------------------------------------------------------------------
// div_sched
// Sequencing controller between the execute unit and the iterative divider.
// Accepts one divide request, holds the divider start level for the whole
// operation, stalls the pipeline, aborts on flush and merges the divider
// result onto the shared register-file write port (ALU has priority).
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   req_valid_i/op/dividend/
//   divisor/rd                   one-cycle divide request from the EXU
//   flush_i                      pipeline flush, cancels an in-flight divide
//   hold_o                       stall request to IF/ID/EX
//   div_start_o/op/dividend/
//   divisor/rd                   command to the divider
//   div_result_i/ready_i/busy_i  divider response
//   alu_we_i                     ALU owns the write port this cycle
//   wb_we_o/addr/data            divider-result register-file write
// ---------------------------------------------------------------------------
module div_sched
    import div_sched_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid_i,
    input  logic [2:0]        req_op_i,
    input  logic [XLEN-1:0]   req_dividend_i,
    input  logic [XLEN-1:0]   req_divisor_i,
    input  logic [REG_AW-1:0] req_rd_i,
    input  logic              flush_i,
    output logic              hold_o,
    output logic              div_start_o,
    output logic [2:0]        div_op_o,
    output logic [XLEN-1:0]   div_dividend_o,
    output logic [XLEN-1:0]   div_divisor_o,
    output logic [REG_AW-1:0] div_rd_o,
    input  logic [XLEN-1:0]   div_result_i,
    input  logic              div_ready_i,
    input  logic              div_busy_i,
    input  logic              alu_we_i,
    output logic              wb_we_o,
    output logic [REG_AW-1:0] wb_addr_o,
    output logic [XLEN-1:0]   wb_data_o
);

    logic [3:0]        state_q,    state_d;
    logic [2:0]        op_q,       op_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [XLEN-1:0]   divisor_q,  divisor_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [XLEN-1:0]   result_q,   result_d;
    logic              wb_fire;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rd_d       = rd_q;
        result_d   = result_q;
        wb_fire    = 1'b0;

        case (state_q)
            DS_IDLE: begin
                // A request coinciding with a flush belongs to a squashed
                // instruction and is dropped.
                if (req_valid_i && !flush_i) begin
                    state_d    = DS_RUN;
                    op_d       = req_op_i;
                    dividend_d = req_dividend_i;
                    divisor_d  = req_divisor_i;
                    rd_d       = req_rd_i;
                end
            end
            DS_RUN: begin
                // Flush beats a same-cycle ready: the result is discarded.
                if (flush_i) begin
                    state_d = DS_ABORT;
                end else if (div_ready_i) begin
                    if (alu_we_i) begin
                        result_d = div_result_i;
                        state_d  = DS_PEND;
                    end else begin
                        wb_fire = 1'b1;
                        state_d = DS_IDLE;
                    end
                end
            end
            DS_PEND: begin
                // Instruction is architecturally complete, so flush is
                // deliberately ignored here; only the ALU can delay us.
                if (!alu_we_i) begin
                    wb_fire  = 1'b1;
                    result_d = '0;
                    state_d  = DS_IDLE;
                end
            end
            DS_ABORT: begin
                // One cycle with start low lets the divider return to idle.
                state_d = DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase

        // Divider command registers read as zero whenever we sit in IDLE.
        if (state_d == DS_IDLE) begin
            op_d       = '0;
            dividend_d = '0;
            divisor_d  = '0;
            rd_d       = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= DS_IDLE;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rd_q       <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
        end
    end

    // Start must drop in the ready cycle or the divider relaunches, and in
    // the flush cycle so the divider sees the abort immediately.
    assign div_start_o    = (state_q == DS_RUN) && !div_ready_i && !flush_i;
    assign div_op_o       = op_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_rd_o       = rd_q;

    assign hold_o = ((state_q == DS_IDLE) && req_valid_i && !flush_i) ||
                    (state_q != DS_IDLE);

    // Writes to x0 still complete the handshake but never raise the enable.
    assign wb_we_o   = wb_fire && (rd_q != '0);
    assign wb_addr_o = wb_fire ? rd_q : '0;
    assign wb_data_o = !wb_fire             ? '0       :
                       (state_q == DS_PEND) ? result_q : div_result_i;

    // After an abort cycle the divider must already be idle.
    busy_clear_after_abort: assert property (
        @(posedge clk) disable iff (!rstn)
        (state_q == DS_ABORT) |=> !div_busy_i
    );

endmodule

// File: tb/tb_div_sched.sv
// ---------------------------------------------------------------------------
// tb_div_sched
// Bench for div_sched with a behavioural divider: launches on the start
// level, reports ready at cycle 3 for a zero divisor and cycle 36 otherwise
// (counting the request cycle as 0), and drops its operation if start falls.
// Expected writebacks are queued by the stimulus and popped by a monitor.
// ---------------------------------------------------------------------------
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid_i;
    logic [2:0]        req_op_i;
    logic [XLEN-1:0]   req_dividend_i, req_divisor_i;
    logic [REG_AW-1:0] req_rd_i;
    logic              flush_i;
    logic              hold_o, div_start_o;
    logic [2:0]        div_op_o;
    logic [XLEN-1:0]   div_dividend_o, div_divisor_o;
    logic [REG_AW-1:0] div_rd_o;
    logic [XLEN-1:0]   div_result_i;
    logic              div_ready_i, div_busy_i;
    logic              alu_we_i;
    logic              wb_we_o;
    logic [REG_AW-1:0] wb_addr_o;
    logic [XLEN-1:0]   wb_data_o;

    typedef struct {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_errors = 0;

    always #5 clk = ~clk;

    div_sched #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid_i    (req_valid_i),
        .req_op_i       (req_op_i),
        .req_dividend_i (req_dividend_i),
        .req_divisor_i  (req_divisor_i),
        .req_rd_i       (req_rd_i),
        .flush_i        (flush_i),
        .hold_o         (hold_o),
        .div_start_o    (div_start_o),
        .div_op_o       (div_op_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_rd_o       (div_rd_o),
        .div_result_i   (div_result_i),
        .div_ready_i    (div_ready_i),
        .div_busy_i     (div_busy_i),
        .alu_we_i       (alu_we_i),
        .wb_we_o        (wb_we_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural divider ----------------
    function automatic logic [31:0] ref_div(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            INST_DIV:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a :
                                 32'($signed(a) / $signed(b));
            INST_DIVU: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            INST_REM:  ref_div = (b == 0) ? a : ovf ? 32'h0 :
                                 32'($signed(a) % $signed(b));
            default:   ref_div = (b == 0) ? a : a % b;
        endcase
    endfunction

    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    int          m_lat  = 0;
    logic [31:0] m_res  = '0;

    initial begin
        div_ready_i  = 1'b0;
        div_busy_i   = 1'b0;
        div_result_i = '0;
    end

    always @(posedge clk) begin
        logic        start_s;
        logic [2:0]  op_s;
        logic [31:0] a_s, b_s;
        start_s = div_start_o;
        op_s    = div_op_o;
        a_s     = div_dividend_o;
        b_s     = div_divisor_o;
        #1;
        div_ready_i  = 1'b0;
        div_result_i = '0;
        if (!rstn) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (!start_s) begin
                m_busy = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    div_ready_i  = 1'b1;
                    div_result_i = m_res;
                    m_busy       = 1'b0;
                end
            end
        end else if (start_s) begin
            m_busy = 1'b1;
            m_cnt  = 1;
            m_lat  = (b_s == 0) ? 2 : 35;
            m_res  = ref_div(op_s, a_s, b_s);
        end
        div_busy_i = m_busy;
    end

    // ---------------- writeback monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && wb_we_o) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 64'(wb_we_o), 64'd0);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    check("wb_addr", 64'(wb_addr_o), 64'(e.addr));
                    check("wb_data", 64'(wb_data_o), 64'(e.data));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [REG_AW-1:0] addr, input logic [XLEN-1:0] data);
        wb_exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drives the request in the current cycle (cycle 0), returns in cycle 1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [REG_AW-1:0] rd);
        req_valid_i    = 1'b1;
        req_op_i       = op;
        req_dividend_i = a;
        req_divisor_i  = b;
        req_rd_i       = rd;
        #1;
        check("hold_on_req", 64'(hold_o), 64'd1);
        step();
        req_valid_i    = 1'b0;
        req_op_i       = '0;
        req_dividend_i = '0;
        req_divisor_i  = '0;
        req_rd_i       = '0;
    endtask

    // Advances until div_ready_i is seen; n = cycles waited after cycle 1.
    task automatic wait_ready(output int n);
        n = 0;
        while (!div_ready_i && n < 200) begin
            step();
            n++;
        end
        if (!div_ready_i) check("ready_timeout", 64'(div_ready_i), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        rstn           = 1'b0;
        req_valid_i    = 1'b0;
        req_op_i       = '0;
        req_dividend_i = '0;
        req_divisor_i  = '0;
        req_rd_i       = '0;
        flush_i        = 1'b0;
        alu_we_i       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold",  64'(hold_o), 64'd0);
        check("rst_start", 64'(div_start_o), 64'd0);
        check("rst_div",   {div_op_o, div_rd_o, div_dividend_o, div_divisor_o[23:0]}, 64'd0);
        check("rst_wb",    {wb_we_o, wb_addr_o, wb_data_o}, 64'd0);
        step();
        rstn = 1'b1;
        step();

        // 1: DIVU 100/7 -> 14 to x5, no ALU traffic
        push_exp(5'd5, 32'd14);
        issue(INST_DIVU, 32'd100, 32'd7, 5'd5);
        @(negedge clk);
        check("t1_start_c1", 64'(div_start_o), 64'd1);
        check("t1_op",       64'(div_op_o), 64'(INST_DIVU));
        wait_ready(n);
        @(negedge clk);
        check("t1_start_ready", 64'(div_start_o), 64'd0);
        check("t1_we_ready",    64'(wb_we_o), 64'd1);
        check("t1_hold_ready",  64'(hold_o), 64'd1);
        step();
        check("t1_hold_after", 64'(hold_o), 64'd0);
        check("t1_idle_zero",  64'(div_dividend_o), 64'd0);

        // 2: REM -7/2 with ALU owning the port for 3 cycles from ready
        push_exp(5'd7, 32'hFFFF_FFFF);
        issue(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd7);
        wait_ready(n);
        alu_we_i = 1'b1;
        @(negedge clk);
        check("t2_we_ready",    64'(wb_we_o), 64'd0);
        check("t2_start_ready", 64'(div_start_o), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("t2_pend_we",    64'(wb_we_o), 64'd0);
            check("t2_pend_hold",  64'(hold_o), 64'd1);
            check("t2_pend_start", 64'(div_start_o), 64'd0);
        end
        step();
        alu_we_i = 1'b0;
        @(negedge clk);
        check("t2_we_r3", 64'(wb_we_o), 64'd1);
        step();
        check("t2_hold_after", 64'(hold_o), 64'd0);

        // 3: DIV 5/0 -> ready at cycle 3, -1 to x3, hold 4 cycles
        push_exp(5'd3, 32'hFFFF_FFFF);
        issue(INST_DIV, 32'd5, 32'd0, 5'd3);
        wait_ready(n);
        check("t3_ready_cycle", 64'(n + 1), 64'd3);
        @(negedge clk);
        check("t3_we", 64'(wb_we_o), 64'd1);
        step();
        check("t3_hold_after", 64'(hold_o), 64'd0);

        // 4: DIV 1000/3 flushed at cycle 10, then DIVU 9/3 -> 3 to x10
        issue(INST_DIV, 32'd1000, 32'd3, 5'd9);
        repeat (9) step();
        flush_i = 1'b1;
        @(negedge clk);
        check("t4_start_flush", 64'(div_start_o), 64'd0);
        check("t4_we_flush",    64'(wb_we_o), 64'd0);
        step();
        flush_i = 1'b0;
        check("t4_abort_hold",  64'(hold_o), 64'd1);
        check("t4_abort_start", 64'(div_start_o), 64'd0);
        step();
        check("t4_idle_hold", 64'(hold_o), 64'd0);
        push_exp(5'd10, 32'd3);
        issue(INST_DIVU, 32'd9, 32'd3, 5'd10);
        wait_ready(n);
        step();
        check("t4b_hold_after", 64'(hold_o), 64'd0);

        // 5a: flush coincident with ready -> no write
        issue(INST_DIVU, 32'd20, 32'd4, 5'd11);
        wait_ready(n);
        flush_i = 1'b1;
        @(negedge clk);
        check("t5_we_flush_ready", 64'(wb_we_o), 64'd0);
        step();
        flush_i = 1'b0;
        check("t5_abort_hold", 64'(hold_o), 64'd1);
        step();
        check("t5_idle_hold", 64'(hold_o), 64'd0);

        // 5b: DIVU to x0 -> handshake completes, no write enable
        issue(INST_DIVU, 32'd6, 32'd3, 5'd0);
        wait_ready(n);
        @(negedge clk);
        check("t5b_we_rd0",   64'(wb_we_o), 64'd0);
        check("t5b_start_rd0", 64'(div_start_o), 64'd0);
        step();
        check("t5b_hold_after", 64'(hold_o), 64'd0);

        // 6: reset at cycle 20 of a divide, then DIVU 8/2 -> 4 to x13
        issue(INST_DIVU, 32'd1000, 32'd10, 5'd12);
        repeat (19) step();
        rstn = 1'b0;
        @(negedge clk);
        check("t6_rst_ctl", {hold_o, div_start_o, wb_we_o}, 64'd0);
        check("t6_rst_div", {div_op_o, div_rd_o, div_dividend_o, div_divisor_o[23:0]}, 64'd0);
        check("t6_rst_wb",  {wb_addr_o, wb_data_o}, 64'd0);
        step();
        rstn = 1'b1;
        step();
        push_exp(5'd13, 32'd4);
        issue(INST_DIVU, 32'd8, 32'd2, 5'd13);
        wait_ready(n);
        step();
        check("t6_hold_after", 64'(hold_o), 64'd0);

        repeat (3) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
